maxpool2x2_cx: RTL and testbench

Channel-parallel 2x2, stride-2 max-pooling stage placed directly downstream of the multi-output pointwise convolution. It consumes one pixel per valid cycle: a vector of CHANNEL signed fixed-point values in raster order over an INPUT_SIZE x INPUT_SIZE map. It emits (INPUT_SIZE/2)^2 pooled vectors per frame, with a frame-end flag in the same style as the conv stage.

---
 rtl/maxpool2x2_cx_pkg.sv | 20 ++
 rtl/maxpool2x2_cx_max_lane.sv | 43 ++++
 rtl/maxpool2x2_cx.sv | 92 +++++++++
 tb/tb_maxpool2x2_cx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool2x2_cx_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pooling stage.
// The signed max helper is width-generic: callers sign-extend into MAXW and truncate back.
package maxpool2x2_cx_pkg;

  // Position of the current pixel inside its 2x2 window: {row[0], col[0]}.
  typedef enum logic [1:0] {
    PH_EE = 2'b00,
    PH_EO = 2'b01,
    PH_OE = 2'b10,
    PH_OO = 2'b11
  } phase_t;

  localparam int MAXW = 64;

  function automatic logic signed [MAXW-1:0] nn_smax(input logic signed [MAXW-1:0] a,
                                                     input logic signed [MAXW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2x2_cx_max_lane.sv
// One channel lane of the pooling datapath: horizontal register, compares and output register.
// Addressing and flags live in the top; this lane only reacts to the window phase.
module max_lane
  import maxpool2x2_cx_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                i_clr,
  input  logic                i_acc,
  input  phase_t              i_phase,
  input  logic signed [N-1:0] i_din,
  input  logic signed [N-1:0] i_lb,
  output logic signed [N-1:0] o_lb_wr,
  output logic signed [N-1:0] o_dout
);

  logic signed [N-1:0] r_hreg;
  logic signed [N-1:0] r_dout;
  logic signed [N-1:0] w_max_h;
  logic signed [N-1:0] w_max_l;

  assign w_max_h = N'(nn_smax(MAXW'(r_hreg), MAXW'(i_din)));
  assign w_max_l = N'(nn_smax(MAXW'(i_lb), MAXW'(i_din)));

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_hreg <= '0;
      r_dout <= '0;
    end else if (i_acc) begin
      case (i_phase)
        PH_EE:   r_hreg <= i_din;
        PH_OE:   r_hreg <= w_max_l;
        PH_OO:   r_dout <= w_max_h;
        default: r_hreg <= r_hreg;
      endcase
    end
  end

  assign o_lb_wr = w_max_h;
  assign o_dout  = r_dout;

endmodule

// File: rtl/maxpool2x2_cx.sv
// Channel-parallel 2x2 stride-2 max pooling over a raster-order INPUT_SIZE x INPUT_SIZE map.
// Handshake: a pixel is accepted when din_vld=1 and ce=1; there is no backpressure, dout_vld is a 1-cycle strobe.
module maxpool2x2_cx
  import maxpool2x2_cx_pkg::*;
#(
  parameter int N          = 16,
  parameter int CHANNEL    = 32,
  parameter int INPUT_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 din_vld,
  input  logic [CHANNEL*N-1:0] din,
  output logic [CHANNEL*N-1:0] dout,
  output logic                 dout_vld,
  output logic                 dout_end
);

  localparam int HALF = INPUT_SIZE / 2;
  localparam int CW   = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int LBW  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

  logic [CW-1:0]        r_col;
  logic [CW-1:0]        r_row;
  logic                 r_vld;
  logic                 r_end;
  logic [CHANNEL*N-1:0] r_linebuf [HALF];

  logic                 w_clr;
  logic                 w_acc;
  phase_t               w_phase;
  logic [LBW-1:0]       w_lb_idx;
  logic [CHANNEL*N-1:0] w_lb_rd;
  logic [CHANNEL*N-1:0] w_lb_wr;

  assign w_clr    = !rst_n || !ce;
  assign w_acc    = ce && din_vld;
  assign w_phase  = phase_t'({r_row[0], r_col[0]});
  assign w_lb_idx = LBW'(r_col >> 1);
  assign w_lb_rd  = r_linebuf[w_lb_idx];

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_col <= '0;
      r_row <= '0;
      r_vld <= 1'b0;
      r_end <= 1'b1;
    end else begin
      r_vld <= w_acc && (w_phase == PH_OO);
      if (w_acc) begin
        if (r_col == LAST) begin
          r_col <= '0;
          r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        // First and last pixel of a frame are distinct, so set and clear never collide.
        if (r_row == '0 && r_col == '0) begin
          r_end <= 1'b0;
        end else if (r_row == LAST && r_col == LAST) begin
          r_end <= 1'b1;
        end
      end
    end
  end

  // Contents need no reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (!w_clr && w_acc && (w_phase == PH_EO)) begin
      r_linebuf[w_lb_idx] <= w_lb_wr;
    end
  end

  for (genvar g = 0; g < CHANNEL; g++) begin : g_lane
    max_lane #(.N(N)) u_lane (
      .clk     (clk),
      .i_clr   (w_clr),
      .i_acc   (w_acc),
      .i_phase (w_phase),
      .i_din   (din[g*N +: N]),
      .i_lb    (w_lb_rd[g*N +: N]),
      .o_lb_wr (w_lb_wr[g*N +: N]),
      .o_dout  (dout[g*N +: N])
    );
  end

  assign dout_vld = r_vld;
  assign dout_end = r_end;

endmodule

// File: tb/tb_maxpool2x2_cx.sv
// Directed bench for maxpool2x2_cx with N=16, CHANNEL=2, INPUT_SIZE=4.
module tb_maxpool2x2_cx;

  localparam int N  = 16;
  localparam int CH = 2;
  localparam int IS = 4;

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic          din_vld;
  logic [CH*N-1:0] din;
  logic [CH*N-1:0] dout;
  logic          dout_vld;
  logic          dout_end;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int end_cnt = 0;

  logic [CH*N-1:0] got_q[$];
  logic            got_end_q[$];
  int              got_cyc_q[$];
  int              acc_q[$];
  logic [CH*N-1:0] exp_q[$];
  logic            exp_end_q[$];

  maxpool2x2_cx #(.N(N), .CHANNEL(CH), .INPUT_SIZE(IS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .din_vld  (din_vld),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_end (dout_end)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // output monitor, sampled 1ns after each active edge
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (dout_vld) begin
      got_q.push_back(dout);
      got_end_q.push_back(dout_end);
      got_cyc_q.push_back(cyc);
    end
    if (dout_end) end_cnt = end_cnt + 1;
  end

  function automatic logic [CH*N-1:0] pack(input int a, input int b);
    logic [31:0] x;
    logic [31:0] y;
    x = a;
    y = b;
    return {y[15:0], x[15:0]};
  endfunction

  // driver tasks
  task automatic clear_sb();
    got_q.delete();
    got_end_q.delete();
    got_cyc_q.delete();
    acc_q.delete();
    exp_q.delete();
    exp_end_q.delete();
  endtask

  task automatic send_pixel(input int a, input int b, input int r, input int c);
    @(negedge clk);
    din_vld = 1'b1;
    din     = pack(a, b);
    if ((r % 2 == 1) && (c % 2 == 1)) acc_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_vld = 1'b0;
    end
  endtask

  task automatic send_ramp(input int off, input bit gap, input int npix);
    for (int k = 0; k < npix; k++) begin
      send_pixel(k + off, -(k + off), k / IS, k % IS);
      if (gap) idle(1);
    end
  endtask

  task automatic push_ramp_exp(input int off);
    exp_q.push_back(pack(5 + off, -(0 + off)));   exp_end_q.push_back(1'b0);
    exp_q.push_back(pack(7 + off, -(2 + off)));   exp_end_q.push_back(1'b0);
    exp_q.push_back(pack(13 + off, -(8 + off)));  exp_end_q.push_back(1'b0);
    exp_q.push_back(pack(15 + off, -(10 + off))); exp_end_q.push_back(1'b1);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; din_vld = 1'b1; din = pack(123, -45);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dout !== '0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", dout); end
    n_cmp++;
    if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", dout_vld); end
    n_cmp++;
    if (dout_end !== 1'b1) begin n_bad++; $display("FAIL reset_end: got %b want 1", dout_end); end
    rst_n = 1'b1; din_vld = 1'b0;
  endtask

  task automatic test_ramp();
    clear_sb();
    push_ramp_exp(0);
    send_ramp(0, 1'b0, IS * IS);
    idle(3);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL ramp_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_end_q[i] !== exp_end_q[i]) begin
        n_bad++;
        $display("FAIL ramp_out%0d: got %h end %b want %h end %b", i, got_q[i], got_end_q[i], exp_q[i], exp_end_q[i]);
      end
    end
    n_cmp++;
    if (dout_end !== 1'b1) begin n_bad++; $display("FAIL ramp_end_hold: got %b want 1", dout_end); end
  endtask

  task automatic test_signed();
    int l0;
    clear_sb();
    for (int k = 0; k < IS * IS; k++) begin
      case (k)
        0:       l0 = -3;
        1:       l0 = -1;
        4:       l0 = -8;
        5:       l0 = -2;
        default: l0 = -32768;
      endcase
      send_pixel(l0, -32768, k / IS, k % IS);
    end
    idle(3);
    n_cmp++;
    if (got_q.size() !== 4) begin n_bad++; $display("FAIL signed_count: got %0d want 4", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++;
      if (got_q[0] !== 32'h8000_FFFF) begin
        n_bad++; $display("FAIL signed_first: got %h want 8000ffff", got_q[0]);
      end
    end
    for (int i = 1; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== 32'h8000_8000) begin
        n_bad++; $display("FAIL signed_rest%0d: got %h want 80008000", i, got_q[i]);
      end
    end
  endtask

  task automatic test_gapped();
    clear_sb();
    push_ramp_exp(0);
    send_ramp(0, 1'b1, IS * IS);
    idle(3);
    n_cmp++;
    if (got_q.size() !== 4 || acc_q.size() !== 4) begin
      n_bad++; $display("FAIL gap_count: got %0d outputs %0d odd/odd inputs want 4", got_q.size(), acc_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size() && i < acc_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL gap_out%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
      n_cmp++;
      if (got_cyc_q[i] !== acc_q[i]) begin
        n_bad++; $display("FAIL gap_latency%0d: strobe cycle %0d want %0d", i, got_cyc_q[i], acc_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    clear_sb();
    send_ramp(0, 1'b0, 6);
    idle(2);
    clear_sb();
    @(negedge clk);
    ce = 1'b0; din_vld = 1'b1; din = pack(77, 77);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (dout_vld !== 1'b0 || dout_end !== 1'b1) begin
        n_bad++; $display("FAIL abort_ce_low: vld %b end %b want vld 0 end 1", dout_vld, dout_end);
      end
    end
    ce = 1'b1; din_vld = 1'b0;
    push_ramp_exp(0);
    send_ramp(0, 1'b0, IS * IS);
    idle(3);
    n_cmp++;
    if (got_q.size() !== 4) begin n_bad++; $display("FAIL abort_count: got %0d want 4", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_end_q[i] !== exp_end_q[i]) begin
        n_bad++; $display("FAIL abort_out%0d: got %h end %b want %h end %b", i, got_q[i], got_end_q[i], exp_q[i], exp_end_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    push_ramp_exp(0);
    push_ramp_exp(100);
    send_pixel(0, 0, 0, 0);
    end_cnt = 0;
    for (int k = 1; k < IS * IS; k++) send_pixel(k, -k, k / IS, k % IS);
    send_ramp(100, 1'b0, IS * IS);
    idle(3);
    n_cmp++;
    if (got_q.size() !== 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_end_q[i] !== exp_end_q[i]) begin
        n_bad++; $display("FAIL b2b_out%0d: got %h end %b want %h end %b", i, got_q[i], got_end_q[i], exp_q[i], exp_end_q[i]);
      end
    end
    // one cycle between frames plus three idle cycles after the second frame
    n_cmp++;
    if (end_cnt !== 4) begin n_bad++; $display("FAIL b2b_end_cycles: got %0d want 4", end_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    send_ramp(0, 1'b0, 9);
    @(negedge clk);
    rst_n = 1'b0; din_vld = 1'b1; din = pack(99, 99);
    @(negedge clk);
    n_cmp++;
    if (dout !== '0 || dout_vld !== 1'b0 || dout_end !== 1'b1) begin
      n_bad++; $display("FAIL midrst_state: dout %h vld %b end %b want 0 0 1", dout, dout_vld, dout_end);
    end
    rst_n = 1'b1; din_vld = 1'b0;
    clear_sb();
    push_ramp_exp(0);
    send_ramp(0, 1'b0, IS * IS);
    idle(3);
    n_cmp++;
    if (got_q.size() !== 4) begin n_bad++; $display("FAIL midrst_count: got %0d want 4", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_end_q[i] !== exp_end_q[i]) begin
        n_bad++; $display("FAIL midrst_out%0d: got %h end %b want %h end %b", i, got_q[i], got_end_q[i], exp_q[i], exp_end_q[i]);
      end
    end
  endtask

  // sequence and final report
  initial begin
    rst_n = 1'b0; ce = 1'b1; din_vld = 1'b0; din = '0;
    test_reset();
    test_ramp();
    test_signed();
    test_gapped();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
